// File: rtl/hs_ram_arbiter_if.sv
// Bus bundle between the hiscore engine, the game CPU, the work-RAM port and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/RAM side.
interface hs_ram_arbiter_if #(
  parameter int AW = 12
);
  logic          ext_pause;
  logic          hs_req;
  logic          hs_gnt;
  logic [AW-1:0] hs_addr;
  logic [7:0]    hs_wdata;
  logic          hs_we;
  logic [7:0]    hs_rdata;
  logic          hs_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata;
  logic          cpu_pause;
  logic          hs_timeout;

  modport master (
    output ext_pause, hs_req, hs_addr, hs_wdata, hs_we,
           cpu_addr, cpu_wdata, cpu_we, ram_rdata,
    input  hs_gnt, hs_rdata, hs_rvalid, ram_addr, ram_wdata, ram_we,
           cpu_pause, hs_timeout
  );

  modport slave (
    input  ext_pause, hs_req, hs_addr, hs_wdata, hs_we,
           cpu_addr, cpu_wdata, cpu_we, ram_rdata,
    output hs_gnt, hs_rdata, hs_rvalid, ram_addr, ram_wdata, ram_we,
           cpu_pause, hs_timeout
  );
endinterface

// File: rtl/hs_ram_arbiter.sv
// Work-RAM port arbiter: pauses the CPU, drains, then lends the RAM port to the hiscore engine.
// Optional grant watchdog enabled by defining HS_ARB_TIMEOUT_EN.
module hs_ram_arbiter #(
  parameter int AW     = 12,
  parameter int SETTLE = 8,
  parameter int TMO    = 4096
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  hs_ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  // Out-of-range parameters leave a marker scope in the elaborated hierarchy.
  if (SETTLE < 1 || SETTLE > 255 || TMO < 1 || TMO > 65536 || AW < 1) begin : g_bad_params
  end

  state_t     state_q, state_d;
  logic [7:0] drain_q, drain_d;
  logic       gnt_q, gnt_d;
  logic       pause_q, pause_d;
  logic       rvalid_q, rvalid_d;
  logic [7:0] rdata_q, rdata_d;
  logic       tmo_hit;
  logic       block_req;
  logic       timeout_flag;

`ifdef HS_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  logic [15:0] tmo_q, tmo_d;
  logic        wait_low_q, wait_low_d;
  logic        timeout_q, timeout_d;

  assign tmo_hit      = (state_q == GRANT) && (tmo_q == TMO_LAST);
  assign block_req    = wait_low_q;
  assign timeout_flag = timeout_q;

  // Counter sits at zero outside GRANT so every grant starts a fresh window.
  always_comb begin
    tmo_d      = tmo_q;
    wait_low_d = wait_low_q;
    timeout_d  = timeout_q;
    if (state_q != GRANT) begin
      tmo_d = '0;
    end else if (!tmo_hit) begin
      tmo_d = tmo_q + 16'd1;
    end
    if (tmo_hit && bus.hs_req) begin
      wait_low_d = 1'b1;
      timeout_d  = 1'b1;
    end else if (state_q == IDLE && !bus.hs_req) begin
      wait_low_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q      <= '0;
      wait_low_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      wait_low_q <= wait_low_d;
      timeout_q  <= timeout_d;
    end
  end
`else
  assign tmo_hit      = 1'b0;
  assign block_req    = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (bus.hs_req && !block_req) begin
          state_d = DRAIN;
          drain_d = SETTLE_M1;
        end
      end
      DRAIN: begin
        // A withdrawn request wins over an expiring drain count.
        if (!bus.hs_req) begin
          state_d = RELEASE;
        end else if (drain_q == 8'd0) begin
          state_d = GRANT;
        end else begin
          drain_d = drain_q - 8'd1;
        end
      end
      GRANT: begin
        if (!bus.hs_req || tmo_hit) begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    gnt_d    = (state_d == GRANT);
    pause_d  = (state_d != IDLE) | bus.ext_pause;
    rvalid_d = gnt_q & ~bus.hs_we;
    rdata_d  = rvalid_q ? bus.ram_rdata : rdata_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      drain_q  <= '0;
      gnt_q    <= 1'b0;
      pause_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      gnt_q    <= gnt_d;
      pause_q  <= pause_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Mux select is the grant register itself, so reset hands the port back at once.
  assign bus.ram_addr  = gnt_q ? bus.hs_addr  : bus.cpu_addr;
  assign bus.ram_wdata = gnt_q ? bus.hs_wdata : bus.cpu_wdata;
  assign bus.ram_we    = gnt_q ? bus.hs_we    : bus.cpu_we;

  // The RAM output register carries the result during the valid pulse; rdata_q holds it afterwards.
  assign bus.hs_rdata   = rvalid_q ? bus.ram_rdata : rdata_q;
  assign bus.hs_rvalid  = rvalid_q;
  assign bus.hs_gnt     = gnt_q;
  assign bus.cpu_pause  = pause_q;
  assign bus.hs_timeout = timeout_flag;

endmodule
